// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared multicycle ARM datapath: walks each instruction through
// fetch/decode/execute/memory/writeback and stalls on the memory handshake.
module multicycle_ctrl #(
    parameter bit MEM_HS    = 1'b1,
    parameter bit CMP_NO_WB = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       CondEx,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       PCWrite,
    output logic       RegW,
    output logic       MemW,
    output logic       MemB,
    output logic       Retire
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_ORR  = 3'b011;
    localparam logic [2:0] ALU_EOR  = 3'b100;
    localparam logic [2:0] ALU_PASS = 3'b101;

    state_t     state;
    state_t     next_state;
    logic       ready;
    logic       is_cmp;
    logic       rd_pc;
    logic       flag_nz;
    logic       arith;
    logic [2:0] dp_alu;

    // With the handshake disabled the memory is assumed to finish every access in one cycle.
    assign ready   = MEM_HS ? MemReady : 1'b1;
    assign is_cmp  = (Funct[4:3] == 2'b10);
    assign rd_pc   = (Rd == 4'd15);
    assign flag_nz = (Funct[0] | is_cmp) & CondEx;
    assign arith   = (dp_alu == ALU_ADD) || (dp_alu == ALU_SUB);

    always_comb begin
        case (Funct[4:1])
            4'b0100: dp_alu = ALU_ADD;
            4'b0010: dp_alu = ALU_SUB;
            4'b0000: dp_alu = ALU_AND;
            4'b1100: dp_alu = ALU_ORR;
            4'b0001: dp_alu = ALU_EOR;
            4'b1000: dp_alu = ALU_AND;
            4'b1001: dp_alu = ALU_EOR;
            4'b1010: dp_alu = ALU_SUB;
            4'b1011: dp_alu = ALU_ADD;
            4'b1101: dp_alu = ALU_PASS;
            default: dp_alu = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // Reset forces fetch-style selects and kills every write strobe in the same cycle.
    always_comb begin
        next_state = state;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = {Op == 2'b01, Op == 2'b10};
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        PCWrite    = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        MemB       = 1'b0;
        Retire     = 1'b0;
        if (reset) begin
            next_state = FETCH;
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
        end else begin
            case (state)
                FETCH: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = ready;
                    PCWrite   = ready;
                    if (ready) next_state = DECODE;
                end
                DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    case (Op)
                        2'b01:   next_state = MEMADR;
                        2'b10:   next_state = BRANCH;
                        2'b00:   next_state = Funct[5] ? EXECI : EXECR;
                        default: next_state = UNKNOWN;
                    endcase
                end
                MEMADR: begin
                    ALUSrcB    = 2'b01;
                    ImmSrc     = 2'b01;
                    ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
                    next_state = Funct[0] ? MEMREAD : MEMWRITE;
                end
                MEMREAD: begin
                    AdrSrc = 1'b1;
                    MemB   = Funct[2];
                    if (ready) next_state = MEMWB;
                end
                MEMWRITE: begin
                    AdrSrc = 1'b1;
                    MemW   = CondEx;
                    MemB   = Funct[2];
                    if (ready) begin
                        Retire     = 1'b1;
                        next_state = FETCH;
                    end
                end
                MEMWB: begin
                    ResultSrc  = 2'b01;
                    RegW       = CondEx;
                    PCWrite    = CondEx & rd_pc;
                    Retire     = 1'b1;
                    next_state = FETCH;
                end
                EXECR, EXECI: begin
                    ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
                    ALUControl = dp_alu;
                    FlagW      = {flag_nz, flag_nz & arith};
                    if (is_cmp && CMP_NO_WB) begin
                        Retire     = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = ALUWB;
                    end
                end
                ALUWB: begin
                    RegW       = CondEx & ~is_cmp;
                    PCWrite    = CondEx & ~is_cmp & rd_pc;
                    Retire     = 1'b1;
                    next_state = FETCH;
                end
                BRANCH: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b01;
                    ImmSrc     = 2'b10;
                    ResultSrc  = 2'b10;
                    PCWrite    = CondEx;
                    RegW       = Funct[4] & CondEx;
                    Retire     = 1'b1;
                    next_state = FETCH;
                end
                UNKNOWN: begin
                    Retire     = 1'b1;
                    next_state = FETCH;
                end
                default: next_state = FETCH;
            endcase
        end
    end

endmodule
